// File: rtl/nukv_privacy_dispatch.sv
// Predicate-steered value dispatcher: routes each value packet to one of NUM_PATHS lanes
// (or drops it) and re-merges lane results in original packet order.
module nukv_privacy_dispatch #(
    parameter int         MEMORY_WIDTH        = 512,
    parameter int         NUM_PATHS           = 4,
    parameter int         VALUE_SIZE_BYTES_NO = 2,
    parameter int         ORDER_ADDR_BITS     = 5,
    parameter logic [7:0] DROP_CODE           = 8'hFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MEMORY_WIDTH-1:0]           pred_data,
    input  logic                              pred_valid,
    output logic                              pred_ready,
    input  logic [MEMORY_WIDTH-1:0]           value_data,
    input  logic                              value_valid,
    input  logic                              value_last,
    output logic                              value_ready,
    output logic [NUM_PATHS*MEMORY_WIDTH-1:0] lane_out_data,
    output logic [NUM_PATHS-1:0]              lane_out_valid,
    output logic [NUM_PATHS-1:0]              lane_out_last,
    input  logic [NUM_PATHS-1:0]              lane_out_ready,
    input  logic [NUM_PATHS*MEMORY_WIDTH-1:0] lane_in_data,
    input  logic [NUM_PATHS-1:0]              lane_in_valid,
    input  logic [NUM_PATHS-1:0]              lane_in_last,
    output logic [NUM_PATHS-1:0]              lane_in_ready,
    output logic [MEMORY_WIDTH-1:0]           output_data,
    output logic                              output_valid,
    output logic                              output_last,
    input  logic                              output_ready,
    output logic [31:0]                       cnt_packets_out,
    output logic [31:0]                       cnt_dropped,
    output logic                              err_bad_sel
);
    localparam int LW      = $clog2(NUM_PATHS);
    localparam int DEPTH   = 2 ** ORDER_ADDR_BITS;
    localparam int SEL_LSB = 8 * VALUE_SIZE_BYTES_NO;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                     state_q, state_d;
    logic [LW-1:0]              cur_q, cur_d;
    logic [LW-1:0]              order_mem_q [DEPTH];
    logic [ORDER_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ORDER_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ORDER_ADDR_BITS:0]   count_q, count_d;
    logic [31:0]                cnt_packets_q, cnt_packets_d;
    logic [31:0]                cnt_dropped_q, cnt_dropped_d;
    logic                       err_q, err_d;

    logic [7:0]    sel;
    logic          sel_in_range;
    logic          push, pop;
    logic          fifo_empty, fifo_full;
    logic [LW-1:0] oc;
    logic          unused_pred;

    assign sel          = pred_data[SEL_LSB +: 8];
    assign sel_in_range = ({24'd0, sel} < 32'(NUM_PATHS));
    assign unused_pred  = ^pred_data;
    assign fifo_empty   = (count_q == '0);
    // Count can only reach DEPTH, so its MSB alone flags full.
    assign fifo_full    = count_q[ORDER_ADDR_BITS];
    assign oc           = order_mem_q[rd_ptr_q];

    assign lane_out_data   = {NUM_PATHS{value_data}};
    assign cnt_packets_out = cnt_packets_q;
    assign cnt_dropped     = cnt_dropped_q;
    assign err_bad_sel     = err_q;

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        err_d          = err_q;
        cnt_dropped_d  = cnt_dropped_q;
        push           = 1'b0;
        pred_ready     = 1'b0;
        value_ready    = 1'b0;
        lane_out_valid = '0;
        lane_out_last  = '0;
        case (state_q)
            IDLE: begin
                pred_ready = !fifo_full && !rst;
                if (pred_valid && pred_ready) begin
                    if (sel_in_range) begin
                        push    = 1'b1;
                        cur_d   = sel[LW-1:0];
                        state_d = FWD;
                    end else begin
                        state_d = DROP;
                        if (sel != DROP_CODE) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            FWD: begin
                lane_out_valid[cur_q] = value_valid;
                lane_out_last[cur_q]  = value_last;
                value_ready           = lane_out_ready[cur_q];
                if (value_valid && value_ready && value_last) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                value_ready = 1'b1;
                if (value_valid && value_last) begin
                    state_d       = IDLE;
                    cnt_dropped_d = cnt_dropped_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side only listens to the lane at the head of the order FIFO.
    always_comb begin
        output_valid  = 1'b0;
        output_last   = 1'b0;
        output_data   = '0;
        lane_in_ready = '0;
        pop           = 1'b0;
        if (!fifo_empty) begin
            output_valid      = lane_in_valid[oc];
            output_last       = lane_in_last[oc];
            output_data       = lane_in_data[int'(oc)*MEMORY_WIDTH +: MEMORY_WIDTH];
            lane_in_ready[oc] = output_ready;
            pop               = lane_in_valid[oc] && output_ready && lane_in_last[oc];
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        cnt_packets_d = cnt_packets_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            cnt_packets_d = cnt_packets_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_packets_q <= '0;
            cnt_dropped_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_packets_q <= cnt_packets_d;
            cnt_dropped_q <= cnt_dropped_d;
            err_q         <= err_d;
        end
    end

    // Lane-id storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            order_mem_q[wr_ptr_q] <= cur_d;
        end
    end
endmodule

// File: tb/tb_nukv_privacy_dispatch.sv
// Randomized bench for nukv_privacy_dispatch: loopback lanes with per-lane tags and delays,
// an expected-beat queue built from the routing rules, and counter/flag expectations.
module tb_nukv_privacy_dispatch;
    localparam int MW      = 64;
    localparam int NP      = 4;
    localparam int VB      = 2;
    localparam int OAB     = 5;
    localparam int SEL_LSB = 8 * VB;

    logic             clk = 1'b0;
    logic             rst;
    logic [MW-1:0]    pred_data;
    logic             pred_valid;
    logic             pred_ready;
    logic [MW-1:0]    value_data;
    logic             value_valid;
    logic             value_last;
    logic             value_ready;
    logic [NP*MW-1:0] lane_out_data;
    logic [NP-1:0]    lane_out_valid;
    logic [NP-1:0]    lane_out_last;
    logic [NP-1:0]    lane_out_ready;
    logic [NP*MW-1:0] lane_in_data;
    logic [NP-1:0]    lane_in_valid;
    logic [NP-1:0]    lane_in_last;
    logic [NP-1:0]    lane_in_ready;
    logic [MW-1:0]    output_data;
    logic             output_valid;
    logic             output_last;
    logic             output_ready;
    logic [31:0]      cnt_packets_out;
    logic [31:0]      cnt_dropped;
    logic             err_bad_sel;

    always #5 clk = ~clk;

    nukv_privacy_dispatch #(
        .MEMORY_WIDTH(MW), .NUM_PATHS(NP), .VALUE_SIZE_BYTES_NO(VB),
        .ORDER_ADDR_BITS(OAB), .DROP_CODE(8'hFF)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(pred_ready),
        .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
        .value_ready(value_ready),
        .lane_out_data(lane_out_data), .lane_out_valid(lane_out_valid),
        .lane_out_last(lane_out_last), .lane_out_ready(lane_out_ready),
        .lane_in_data(lane_in_data), .lane_in_valid(lane_in_valid),
        .lane_in_last(lane_in_last), .lane_in_ready(lane_in_ready),
        .output_data(output_data), .output_valid(output_valid), .output_last(output_last),
        .output_ready(output_ready),
        .cnt_packets_out(cnt_packets_out), .cnt_dropped(cnt_dropped), .err_bad_sel(err_bad_sel)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [MW:0]   exp_q [$];
    int            exp_pkts  = 0;
    int            exp_beats = 0;
    int            exp_drop  = 0;
    logic          exp_err   = 1'b0;
    int            out_beats = 0;

    // Lane model controls and storage
    logic [NP-1:0] lane_hold = '0;
    int            lane_delay [NP] = '{default: 0};
    logic          rand_rdy = 1'b0;
    logic [MW:0]   lq [NP][$];
    int            lt [NP][$];
    int            cyc = 0;
    logic [MW:0]   e;

    // Each lane tags data with its own byte pattern so the merged output proves the route.
    function automatic logic [MW-1:0] xf(input int lane, input logic [MW-1:0] d);
        logic [7:0] k;
        k = 8'(17 * (lane + 1));
        return d ^ {(MW/8){k}};
    endfunction

    always begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                lq[i].delete();
                lt[i].delete();
            end
            lane_in_valid  = '0;
            lane_in_last   = '0;
            lane_in_data   = '0;
            lane_out_ready = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                lane_out_ready[i] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (lq[i].size() > 0 && !lane_hold[i] && cyc >= lt[i][0]) begin
                    lane_in_valid[i]         = 1'b1;
                    lane_in_data[i*MW +: MW] = lq[i][0][MW-1:0];
                    lane_in_last[i]          = lq[i][0][MW];
                end else begin
                    lane_in_valid[i] = 1'b0;
                    lane_in_last[i]  = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < NP; i++) begin
                if (lane_in_valid[i] && lane_in_ready[i]) begin
                    void'(lq[i].pop_front());
                    void'(lt[i].pop_front());
                end
                if (lane_out_valid[i] && lane_out_ready[i]) begin
                    lq[i].push_back({lane_out_last[i], xf(i, lane_out_data[i*MW +: MW])});
                    lt[i].push_back(cyc + lane_delay[i]);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        output_ready = !rst && (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
        #1;
        if (!rst && output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", output_data, e[MW-1:0]);
                check_eq("out_last", {63'd0, output_last}, {63'd0, e[MW]});
                out_beats++;
            end
        end
    end

    task automatic drive_pred(input logic [7:0] sel, output logic ok);
        int   g;
        logic fired;
        g = 0;
        pred_data = {$urandom, $urandom};
        pred_data[SEL_LSB +: 8] = sel;
        pred_valid = 1'b1;
        do begin
            #1;
            fired = pred_ready;
            @(negedge clk);
            g++;
        end while (!fired && g < 3000);
        pred_valid = 1'b0;
        ok = fired;
        if (!fired) check_eq("pred_timeout", {63'd0, pred_ready}, 64'd1);
    endtask

    task automatic drive_beat(input logic [MW-1:0] d, input logic last, input logic [7:0] sel,
                              output logic ok);
        int   g;
        logic fired;
        logic first;
        g = 0;
        first = 1'b1;
        value_data  = d;
        value_last  = last;
        value_valid = 1'b1;
        do begin
            #1;
            if (first) begin
                if (sel < NP) begin
                    check_eq("lane_vld", 64'(lane_out_valid), 64'(1 << sel));
                end else begin
                    check_eq("drop_rdy", {63'd0, value_ready}, 64'd1);
                    check_eq("drop_lane_vld", 64'(lane_out_valid), 64'd0);
                end
                first = 1'b0;
            end
            fired = value_ready;
            @(negedge clk);
            g++;
        end while (!fired && g < 3000);
        value_valid = 1'b0;
        value_last  = 1'b0;
        ok = fired;
        if (!fired) check_eq("beat_timeout", {63'd0, value_ready}, 64'd1);
    endtask

    task automatic send_pkt(input logic [7:0] sel, input int nbeats);
        logic          ok;
        logic [MW-1:0] d;
        drive_pred(sel, ok);
        if (!ok) return;
        if (sel < NP) exp_pkts++;
        for (int b = 0; b < nbeats; b++) begin
            if (rand_rdy) repeat ($urandom_range(0, 1)) @(negedge clk);
            d = {$urandom, $urandom};
            if (sel < NP) begin
                exp_q.push_back({b == nbeats - 1, xf(int'(sel), d)});
                exp_beats++;
            end
            drive_beat(d, b == nbeats - 1, sel, ok);
            if (!ok) return;
        end
        if (sel >= NP) begin
            exp_drop++;
            if (sel != 8'hFF) exp_err = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 4000) check_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_pkts"}, 64'(cnt_packets_out), 64'(exp_pkts));
        check_eq({tag, "_beats"}, 64'(out_beats), 64'(exp_beats));
        check_eq({tag, "_drop"}, 64'(cnt_dropped), 64'(exp_drop));
        check_eq({tag, "_err"}, {63'd0, err_bad_sel}, {63'd0, exp_err});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ctl"}, 64'({pred_ready, value_ready, lane_out_valid, lane_in_ready,
                                     output_valid, output_last}), 64'd0);
        check_eq({tag, "_odata"}, output_data, 64'd0);
        check_eq({tag, "_cnt"}, {cnt_packets_out, cnt_dropped}, 64'd0);
        check_eq({tag, "_err"}, {63'd0, err_bad_sel}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [7:0] s;
        int         r;
        rst         = 1'b1;
        pred_valid  = 1'b0;
        pred_data   = '0;
        value_valid = 1'b0;
        value_data  = '0;
        value_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_pred_rdy", {63'd0, pred_ready}, 64'd1);
        @(negedge clk);

        // In-order routing across all four lanes
        for (int k = 0; k < NP; k++) send_pkt(8'(k), 3);
        drain("t1_drain");
        check_counters("t1");

        // Slow lane 0 must hold back an already-finished lane 1
        lane_delay[0] = 50;
        send_pkt(8'd0, 2);
        send_pkt(8'd1, 2);
        repeat (10) @(negedge clk);
        #1;
        check_eq("t2_l1_vld", {63'd0, lane_in_valid[1]}, 64'd1);
        check_eq("t2_l1_held", {63'd0, lane_in_ready[1]}, 64'd0);
        check_eq("t2_out_vld", {63'd0, output_valid}, 64'd0);
        @(negedge clk);
        drain("t2_drain");
        lane_delay[0] = 0;
        check_counters("t2");

        // Drop code, then an out-of-range selector with traffic after it
        send_pkt(8'hFF, 5);
        repeat (2) @(negedge clk);
        check_counters("t3");
        send_pkt(8'h07, 2);
        send_pkt(8'd2, 1);
        send_pkt(8'd3, 2);
        drain("t4_drain");
        check_counters("t4");

        // Randomized mix with back-pressure, gaps and per-lane latency
        rand_rdy = 1'b1;
        for (int i = 0; i < NP; i++) lane_delay[i] = $urandom_range(0, 6);
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       s = 8'(r % NP);
            else if (r == 7) s = 8'hFF;
            else             s = 8'($urandom_range(NP, 254));
            send_pkt(s, $urandom_range(1, 4));
        end
        drain("rnd_drain");
        rand_rdy = 1'b0;
        for (int i = 0; i < NP; i++) lane_delay[i] = 0;
        check_counters("rnd");

        // Order FIFO full: 32 packets in flight block the 33rd predicate
        lane_hold = '1;
        for (int p = 0; p < (1 << OAB); p++) send_pkt(8'($urandom_range(0, NP - 1)), 1);
        pred_data = '0;
        pred_data[SEL_LSB +: 8] = 8'd1;
        pred_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t5_full_blk", {63'd0, pred_ready}, 64'd0);
            @(negedge clk);
        end
        pred_valid = 1'b0;
        lane_hold = '0;
        send_pkt(8'd1, 1);
        drain("t5_drain");
        check_counters("t5");

        // Reset with three packets queued and a fourth mid-forward
        lane_hold = '1;
        for (int p = 0; p < 3; p++) send_pkt(8'(p), 1);
        drive_pred(8'd2, ok);
        drive_beat({$urandom, $urandom}, 1'b0, 8'd2, ok);
        rst = 1'b1;
        exp_q.delete();
        exp_pkts  = 0;
        exp_beats = 0;
        exp_drop  = 0;
        exp_err   = 1'b0;
        out_beats = 0;
        lane_hold = '0;
        #1;
        check_reset_state("t6_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pkt(8'd3, 2);
        send_pkt(8'd0, 1);
        drain("t6_drain");
        check_counters("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
